id_ctrl_stage: RTL and testbench

- Registered successor to the combinational ID-stage decoder of the pipelined MIPS core.
- Decodes the IF/ID instruction into the ID/EX control bundle and registers it, so ID/EX control lives inside this block.
- Adds multi-source interrupt arbitration with a pending/mask/in-service FSM, stall/flush handling and an optional extended-ISA mode.

---
 rtl/id_ctrl_pkg.sv | 99 +++++++++
 rtl/irq_arbiter.sv | 53 +++++
 rtl/id_ctrl_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_id_ctrl_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_ctrl_pkg.sv
// Shared encodings for the ID control stage: opcodes, functs, PCSrc/ALUFun/cause
// codes, the registered control bundle layout and the FSM state type.
package id_ctrl_pkg;

    localparam logic [2:0] PCSRC_SEQ = 3'b000;
    localparam logic [2:0] PCSRC_BR  = 3'b001;
    localparam logic [2:0] PCSRC_J   = 3'b010;
    localparam logic [2:0] PCSRC_JR  = 3'b011;
    localparam logic [2:0] PCSRC_IRQ = 3'b100;
    localparam logic [2:0] PCSRC_UND = 3'b101;

    localparam logic [5:0] ALU_ADD = 6'h00;
    localparam logic [5:0] ALU_SUB = 6'h01;
    localparam logic [5:0] ALU_AND = 6'h18;
    localparam logic [5:0] ALU_OR  = 6'h1e;
    localparam logic [5:0] ALU_XOR = 6'h16;
    localparam logic [5:0] ALU_NOR = 6'h11;
    localparam logic [5:0] ALU_SLL = 6'h20;
    localparam logic [5:0] ALU_SRL = 6'h21;
    localparam logic [5:0] ALU_SRA = 6'h23;
    localparam logic [5:0] ALU_SLT = 6'h35;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0a;
    localparam logic [5:0] OP_SLTIU  = 6'h0b;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_XORI   = 6'h0e;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_UNDEF = 2'd1;
    localparam logic [1:0] CAUSE_IRQ   = 2'd2;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_SERVICE = 1'b1
    } irq_state_e;

    typedef struct packed {
        logic        ex_valid;
        logic [2:0]  pcsrc;
        logic [1:0]  regdst;
        logic        regwr;
        logic        alusrc1;
        logic        alusrc2;
        logic [5:0]  alufun;
        logic        sign;
        logic        memwr;
        logic        memrd;
        logic [1:0]  memtoreg;
        logic        extop;
        logic        luop;
        logic [25:0] jt;
        logic [5:0]  opcode;
        logic [1:0]  cause;
    } ctrl_t;

    // Exceptions and interrupts share one shape: write the link register ($k0 path) and vector away.
    function automatic ctrl_t trap_bundle(input logic [2:0] pcsrc_code, input logic [1:0] cause_code);
        ctrl_t t;
        t          = '0;
        t.ex_valid = 1'b1;
        t.pcsrc    = pcsrc_code;
        t.regdst   = 2'b11;
        t.regwr    = 1'b1;
        t.memtoreg = 2'b10;
        t.cause    = cause_code;
        return t;
    endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Interrupt front end: rising-edge capture into pending bits, masking,
// fixed lowest-index-first pick and a registered one-hot acknowledge.
module irq_arbiter
    import id_ctrl_pkg::*;
#(
    parameter int NUM_IRQ  = 4,
    parameter int IRQ_ID_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               take,
    output logic               req_any,
    output logic [NUM_IRQ-1:0] ack
);

    logic [NUM_IRQ-1:0]  req_q_r;
    logic [NUM_IRQ-1:0]  pend_r;
    logic [NUM_IRQ-1:0]  ack_r;
    logic [NUM_IRQ-1:0]  cand_s;
    logic [NUM_IRQ-1:0]  rise_s;
    logic [NUM_IRQ-1:0]  onehot_s;
    logic [IRQ_ID_W-1:0] id_s;

    // Pick the lowest-index enabled pending source; scan high to low so the lowest wins.
    always_comb begin
        cand_s = pend_r & irq_mask;
        rise_s = irq_req & ~req_q_r;
        id_s   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            id_s = cand_s[i] ? IRQ_ID_W'(i) : id_s;
        end
        onehot_s = take ? (NUM_IRQ'(1'b1) << id_s) : '0;
    end

    // Edge history, pending set/clear (a coincident new edge wins) and ack pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q_r <= '0;
            pend_r  <= '0;
            ack_r   <= '0;
        end else begin
            req_q_r <= irq_req;
            pend_r  <= (pend_r & ~onehot_s) | rise_s;
            ack_r   <= onehot_s;
        end
    end

    assign req_any = |cand_s;
    assign ack     = ack_r;

endmodule

// File: rtl/id_ctrl_stage.sv
// Registered ID-stage decoder: builds the ID/EX control bundle from the IF/ID
// instruction and injects interrupts through a RUN/SERVICE FSM.
module id_ctrl_stage
    import id_ctrl_pkg::*;
#(
    parameter int NUM_IRQ  = 4,
    parameter int IRQ_ID_W = 2,
    parameter bit EXT_ISA  = 1'b1,
    parameter int PC_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instruction,
    input  logic               id_valid,
    input  logic [PC_W-1:0]    pc_plus_in,
    input  logic               stall,
    input  logic               flush,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               irq_ret,
    output logic               ex_valid,
    output logic [2:0]         PCSrc,
    output logic [1:0]         RegDst,
    output logic               RegWr,
    output logic               ALUSrc1,
    output logic               ALUSrc2,
    output logic [5:0]         ALUFun,
    output logic               Sign,
    output logic               MemWr,
    output logic               MemRd,
    output logic [1:0]         MemtoReg,
    output logic               EXTOp,
    output logic               LUOp,
    output logic [25:0]        JT,
    output logic [5:0]         OpCode,
    output logic [PC_W-1:0]    pc_plus_out,
    output logic [1:0]         cause,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               in_service
);

    irq_state_e      state_r, state_next_s;
    ctrl_t           ctrl_r, dec_s, ctrl_next_s;
    logic [PC_W-1:0] pc_r;
    logic            und_s, req_any_s, inject_s, in_service_s;
    logic [5:0]      op_s, funct_s;
    logic [4:0]      rs_s, rt_s, shamt_s;

    assign op_s     = instruction[31:26];
    assign rs_s     = instruction[25:21];
    assign rt_s     = instruction[20:16];
    assign shamt_s  = instruction[10:6];
    assign funct_s  = instruction[5:0];
    assign inject_s = (state_r == ST_RUN) && id_valid && !stall && !flush && req_any_s;

    irq_arbiter #(.NUM_IRQ(NUM_IRQ), .IRQ_ID_W(IRQ_ID_W)) u_irq_arbiter (
        .clk      (clk),
        .reset    (reset),
        .irq_req  (irq_req),
        .irq_mask (irq_mask),
        .take     (inject_s),
        .req_any  (req_any_s),
        .ack      (irq_ack)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; irq_ret in RUN falls through unchanged.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN:     state_next_s = inject_s ? ST_SERVICE : ST_RUN;
            ST_SERVICE: state_next_s = irq_ret ? ST_RUN : ST_SERVICE;
            default:    state_next_s = ST_RUN;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_service_s = (state_r == ST_SERVICE);
    end

    // Instruction decode table; und_s marks any opcode/funct/field-check failure.
    always_comb begin
        dec_s       = '0;
        dec_s.pcsrc = PCSRC_SEQ;
        dec_s.cause = CAUSE_NONE;
        und_s       = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                case (funct_s)
                    FN_SLL:  begin dec_s.regwr = 1'b1; dec_s.alusrc1 = 1'b1; dec_s.alufun = ALU_SLL; und_s = (rs_s != 5'd0); end
                    FN_SRL:  begin dec_s.regwr = 1'b1; dec_s.alusrc1 = 1'b1; dec_s.alufun = ALU_SRL; und_s = (rs_s != 5'd0); end
                    FN_SRA:  begin dec_s.regwr = 1'b1; dec_s.alusrc1 = 1'b1; dec_s.alufun = ALU_SRA; und_s = (rs_s != 5'd0); end
                    FN_ADD, FN_ADDU: begin dec_s.regwr = 1'b1; dec_s.alufun = ALU_ADD; und_s = (shamt_s != 5'd0); end
                    FN_SUB:  begin dec_s.regwr = 1'b1; dec_s.alufun = ALU_SUB; dec_s.sign = 1'b1; und_s = (shamt_s != 5'd0); end
                    FN_SUBU: begin dec_s.regwr = 1'b1; dec_s.alufun = ALU_SUB; und_s = (shamt_s != 5'd0); end
                    FN_AND:  begin dec_s.regwr = 1'b1; dec_s.alufun = ALU_AND; und_s = (shamt_s != 5'd0); end
                    FN_OR:   begin dec_s.regwr = 1'b1; dec_s.alufun = ALU_OR;  und_s = (shamt_s != 5'd0); end
                    FN_XOR:  begin dec_s.regwr = 1'b1; dec_s.alufun = ALU_XOR; und_s = (shamt_s != 5'd0); end
                    FN_NOR:  begin dec_s.regwr = 1'b1; dec_s.alufun = ALU_NOR; und_s = (shamt_s != 5'd0); end
                    FN_SLT:  begin dec_s.regwr = 1'b1; dec_s.alufun = ALU_SLT; dec_s.sign = 1'b1; und_s = (shamt_s != 5'd0); end
                    FN_SLTU: begin dec_s.regwr = 1'b1; dec_s.alufun = ALU_SLT; und_s = (shamt_s != 5'd0); end
                    FN_JR:   begin dec_s.pcsrc = PCSRC_JR; und_s = (instruction[20:6] != 15'd0); end
                    FN_JALR: begin
                        dec_s.pcsrc    = PCSRC_JR;
                        dec_s.regdst   = 2'b10;
                        dec_s.regwr    = 1'b1;
                        dec_s.memtoreg = 2'b10;
                        und_s          = (rt_s != 5'd0) || (shamt_s != 5'd0);
                    end
                    default: und_s = 1'b1;
                endcase
            end
            OP_J:   begin dec_s.pcsrc = PCSRC_J; dec_s.jt = instruction[25:0]; end
            OP_JAL: begin
                dec_s.pcsrc    = PCSRC_J;
                dec_s.jt       = instruction[25:0];
                dec_s.regdst   = 2'b10;
                dec_s.regwr    = 1'b1;
                dec_s.memtoreg = 2'b10;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                dec_s.pcsrc = PCSRC_BR; dec_s.extop = 1'b1; dec_s.opcode = op_s;
            end
            OP_REGIMM: begin
                dec_s.pcsrc = PCSRC_BR; dec_s.extop = 1'b1; dec_s.opcode = op_s;
                und_s = (rt_s != 5'd1);
            end
            OP_ADDI, OP_ADDIU: begin
                dec_s.regdst = 2'b01; dec_s.alusrc2 = 1'b1; dec_s.regwr = 1'b1;
                dec_s.alufun = ALU_ADD; dec_s.extop = 1'b1; dec_s.sign = 1'b1;
            end
            OP_SLTI: begin
                dec_s.regdst = 2'b01; dec_s.alusrc2 = 1'b1; dec_s.regwr = 1'b1;
                dec_s.alufun = ALU_SLT; dec_s.extop = 1'b1; dec_s.sign = 1'b1;
            end
            OP_SLTIU: begin
                dec_s.regdst = 2'b01; dec_s.alusrc2 = 1'b1; dec_s.regwr = 1'b1; dec_s.alufun = ALU_SLT;
            end
            OP_ANDI: begin
                dec_s.regdst = 2'b01; dec_s.alusrc2 = 1'b1; dec_s.regwr = 1'b1; dec_s.alufun = ALU_AND;
            end
            OP_ORI: begin
                dec_s.regdst = 2'b01; dec_s.alusrc2 = 1'b1; dec_s.regwr = 1'b1; dec_s.alufun = ALU_OR;
                und_s = !EXT_ISA;
            end
            OP_XORI: begin
                dec_s.regdst = 2'b01; dec_s.alusrc2 = 1'b1; dec_s.regwr = 1'b1; dec_s.alufun = ALU_XOR;
                und_s = !EXT_ISA;
            end
            OP_LUI: begin
                dec_s.regdst = 2'b01; dec_s.alusrc2 = 1'b1; dec_s.regwr = 1'b1; dec_s.luop = 1'b1;
                und_s = (rs_s != 5'd0);
            end
            OP_LW: begin
                dec_s.regdst = 2'b01; dec_s.alusrc2 = 1'b1; dec_s.regwr = 1'b1; dec_s.alufun = ALU_ADD;
                dec_s.extop = 1'b1; dec_s.sign = 1'b1; dec_s.memrd = 1'b1; dec_s.memtoreg = 2'b01;
            end
            OP_SW: begin
                dec_s.regdst = 2'b01; dec_s.alusrc2 = 1'b1; dec_s.alufun = ALU_ADD;
                dec_s.extop = 1'b1; dec_s.sign = 1'b1; dec_s.memwr = 1'b1;
            end
            default: und_s = 1'b1;
        endcase
    end

    // Select bubble, undefined-instruction trap or the decoded bundle.
    always_comb begin
        if (!id_valid) begin
            ctrl_next_s = '0;
        end else if (und_s) begin
            ctrl_next_s = trap_bundle(PCSRC_UND, CAUSE_UNDEF);
        end else begin
            ctrl_next_s          = dec_s;
            ctrl_next_s.ex_valid = 1'b1;
        end
    end

    // ID/EX register: flush beats stall beats interrupt inject beats decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_r <= '0;
            pc_r   <= '0;
        end else if (flush) begin
            ctrl_r <= '0;
            pc_r   <= '0;
        end else if (stall) begin
            ctrl_r <= ctrl_r;
            pc_r   <= pc_r;
        end else if (inject_s) begin
            ctrl_r <= trap_bundle(PCSRC_IRQ, CAUSE_IRQ);
            pc_r   <= pc_plus_in - PC_W'(32'd4);
        end else begin
            ctrl_r <= ctrl_next_s;
            pc_r   <= id_valid ? pc_plus_in : '0;
        end
    end

    assign ex_valid    = ctrl_r.ex_valid;
    assign PCSrc       = ctrl_r.pcsrc;
    assign RegDst      = ctrl_r.regdst;
    assign RegWr       = ctrl_r.regwr;
    assign ALUSrc1     = ctrl_r.alusrc1;
    assign ALUSrc2     = ctrl_r.alusrc2;
    assign ALUFun      = ctrl_r.alufun;
    assign Sign        = ctrl_r.sign;
    assign MemWr       = ctrl_r.memwr;
    assign MemRd       = ctrl_r.memrd;
    assign MemtoReg    = ctrl_r.memtoreg;
    assign EXTOp       = ctrl_r.extop;
    assign LUOp        = ctrl_r.luop;
    assign JT          = ctrl_r.jt;
    assign OpCode      = ctrl_r.opcode;
    assign cause       = ctrl_r.cause;
    assign pc_plus_out = pc_r;
    assign in_service  = in_service_s;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed bench for id_ctrl_stage: decode, stall/flush, interrupt FSM, reset and
// both EXT_ISA settings (a second instance built with EXT_ISA=0 shares the inputs).
module tb_id_ctrl_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        id_valid;
    logic [31:0] pc_plus_in;
    logic        stall, flush, irq_ret;
    logic [3:0]  irq_req, irq_mask;

    logic        ex_valid, RegWr, ALUSrc1, ALUSrc2, Sign, MemWr, MemRd, EXTOp, LUOp, in_service;
    logic [2:0]  PCSrc;
    logic [1:0]  RegDst, MemtoReg, cause;
    logic [5:0]  ALUFun, OpCode;
    logic [25:0] JT;
    logic [31:0] pc_plus_out;
    logic [3:0]  irq_ack;

    logic        e0_ex_valid, e0_RegWr, e0_ALUSrc1, e0_ALUSrc2, e0_Sign, e0_MemWr, e0_MemRd, e0_EXTOp, e0_LUOp, e0_in_service;
    logic [2:0]  e0_PCSrc;
    logic [1:0]  e0_RegDst, e0_MemtoReg, e0_cause;
    logic [5:0]  e0_ALUFun, e0_OpCode;
    logic [25:0] e0_JT;
    logic [31:0] e0_pc_plus_out;
    logic [3:0]  e0_irq_ack;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ctrl_stage #(.NUM_IRQ(4), .IRQ_ID_W(2), .EXT_ISA(1'b1), .PC_W(32)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .id_valid(id_valid),
        .pc_plus_in(pc_plus_in), .stall(stall), .flush(flush), .irq_req(irq_req),
        .irq_mask(irq_mask), .irq_ret(irq_ret), .ex_valid(ex_valid), .PCSrc(PCSrc),
        .RegDst(RegDst), .RegWr(RegWr), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2),
        .ALUFun(ALUFun), .Sign(Sign), .MemWr(MemWr), .MemRd(MemRd), .MemtoReg(MemtoReg),
        .EXTOp(EXTOp), .LUOp(LUOp), .JT(JT), .OpCode(OpCode), .pc_plus_out(pc_plus_out),
        .cause(cause), .irq_ack(irq_ack), .in_service(in_service)
    );

    id_ctrl_stage #(.NUM_IRQ(4), .IRQ_ID_W(2), .EXT_ISA(1'b0), .PC_W(32)) dut0 (
        .clk(clk), .reset(reset), .instruction(instruction), .id_valid(id_valid),
        .pc_plus_in(pc_plus_in), .stall(stall), .flush(flush), .irq_req(irq_req),
        .irq_mask(irq_mask), .irq_ret(irq_ret), .ex_valid(e0_ex_valid), .PCSrc(e0_PCSrc),
        .RegDst(e0_RegDst), .RegWr(e0_RegWr), .ALUSrc1(e0_ALUSrc1), .ALUSrc2(e0_ALUSrc2),
        .ALUFun(e0_ALUFun), .Sign(e0_Sign), .MemWr(e0_MemWr), .MemRd(e0_MemRd),
        .MemtoReg(e0_MemtoReg), .EXTOp(e0_EXTOp), .LUOp(e0_LUOp), .JT(e0_JT),
        .OpCode(e0_OpCode), .pc_plus_out(e0_pc_plus_out), .cause(e0_cause),
        .irq_ack(e0_irq_ack), .in_service(e0_in_service)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-shot check of the trap/interrupt-shaped bundle fields.
    task automatic check_trap(input string tag, input logic [2:0] pcsrc_e, input logic [1:0] cause_e);
        check_eq({tag, ".PCSrc"},    64'(PCSrc),    64'(pcsrc_e));
        check_eq({tag, ".RegDst"},   64'(RegDst),   64'd3);
        check_eq({tag, ".MemtoReg"}, 64'(MemtoReg), 64'd2);
        check_eq({tag, ".RegWr"},    64'(RegWr),    64'd1);
        check_eq({tag, ".cause"},    64'(cause),    64'(cause_e));
        check_eq({tag, ".ex_valid"}, 64'(ex_valid), 64'd1);
    endtask

    initial begin
        reset = 1'b0; instruction = 32'h0; id_valid = 1'b0; pc_plus_in = 32'h0;
        stall = 1'b0; flush = 1'b0; irq_ret = 1'b0; irq_req = 4'h0; irq_mask = 4'h0;
        tick(); tick();
        check_eq("rst.ex_valid", 64'(ex_valid), 64'd0);
        check_eq("rst.RegWr", 64'(RegWr), 64'd0);
        check_eq("rst.pc", 64'(pc_plus_out), 64'd0);
        check_eq("rst.in_service", 64'(in_service), 64'd0);
        reset = 1'b1;

        // add then two stall cycles
        instruction = 32'h00221820; id_valid = 1'b1; pc_plus_in = 32'h1004;
        tick();
        check_eq("add.ALUFun", 64'(ALUFun), 64'h00);
        check_eq("add.RegDst", 64'(RegDst), 64'd0);
        check_eq("add.RegWr", 64'(RegWr), 64'd1);
        check_eq("add.ex_valid", 64'(ex_valid), 64'd1);
        check_eq("add.pc", 64'(pc_plus_out), 64'h1004);
        check_eq("add.cause", 64'(cause), 64'd0);
        stall = 1'b1; instruction = 32'hFC000000; pc_plus_in = 32'h2000;
        for (int k = 0; k < 2; k++) begin
            tick();
            check_eq("stall.RegWr", 64'(RegWr), 64'd1);
            check_eq("stall.cause", 64'(cause), 64'd0);
            check_eq("stall.pc", 64'(pc_plus_out), 64'h1004);
        end
        stall = 1'b0;

        // undefined instructions and a decode sweep
        tick(); check_trap("und_op", 3'b101, 2'd1);
        instruction = 32'h00231100; tick(); check_trap("sll_rs", 3'b101, 2'd1);
        instruction = 32'h00031100; tick();
        check_eq("sll.ALUFun", 64'(ALUFun), 64'h20);
        check_eq("sll.ALUSrc1", 64'(ALUSrc1), 64'd1);
        check_eq("sll.cause", 64'(cause), 64'd0);
        instruction = 32'h00221822; tick();
        check_eq("sub.ALUFun", 64'(ALUFun), 64'h01);
        check_eq("sub.Sign", 64'(Sign), 64'd1);
        instruction = 32'h8C220008; tick();
        check_eq("lw.MemRd", 64'(MemRd), 64'd1);
        check_eq("lw.MemtoReg", 64'(MemtoReg), 64'd1);
        check_eq("lw.RegDst", 64'(RegDst), 64'd1);
        check_eq("lw.ALUSrc2", 64'(ALUSrc2), 64'd1);
        check_eq("lw.EXTOp", 64'(EXTOp), 64'd1);
        instruction = 32'hAC220008; tick();
        check_eq("sw.MemWr", 64'(MemWr), 64'd1);
        check_eq("sw.RegWr", 64'(RegWr), 64'd0);
        instruction = 32'h10220004; tick();
        check_eq("beq.PCSrc", 64'(PCSrc), 64'd1);
        check_eq("beq.OpCode", 64'(OpCode), 64'd4);
        check_eq("beq.RegWr", 64'(RegWr), 64'd0);
        instruction = 32'h04210004; tick();
        check_eq("bgez.PCSrc", 64'(PCSrc), 64'd1);
        check_eq("bgez.OpCode", 64'(OpCode), 64'd1);
        instruction = 32'h04220004; tick(); check_trap("bgez_rt", 3'b101, 2'd1);
        instruction = 32'h08123456; tick();
        check_eq("j.PCSrc", 64'(PCSrc), 64'd2);
        check_eq("j.JT", 64'(JT), 64'h0123456);
        check_eq("j.RegWr", 64'(RegWr), 64'd0);
        instruction = 32'h03E00008; tick();
        check_eq("jr.PCSrc", 64'(PCSrc), 64'd3);
        instruction = 32'h03E00808; tick(); check_trap("jr_rd", 3'b101, 2'd1);
        instruction = 32'h3C220001; tick(); check_trap("lui_rs", 3'b101, 2'd1);
        instruction = 32'h342200FF; tick();
        check_eq("ori1.ALUFun", 64'(ALUFun), 64'h1e);
        check_eq("ori1.EXTOp", 64'(EXTOp), 64'd0);
        check_eq("ori1.cause", 64'(cause), 64'd0);
        check_eq("ori0.cause", 64'(e0_cause), 64'd1);
        check_eq("ori0.PCSrc", 64'(e0_PCSrc), 64'd5);

        // interrupt priority: bits 1 and 3 rise together
        instruction = 32'h00221820; id_valid = 1'b0; irq_mask = 4'b1111; irq_req = 4'b1010;
        tick();
        check_eq("prio.pre_bubble", 64'(ex_valid), 64'd0);
        id_valid = 1'b1; pc_plus_in = 32'h104;
        tick();
        check_trap("irq1", 3'b100, 2'd2);
        check_eq("irq1.pc", 64'(pc_plus_out), 64'h100);
        check_eq("irq1.ack", 64'(irq_ack), 64'b0010);
        check_eq("irq1.in_service", 64'(in_service), 64'd1);
        tick();
        check_eq("svc.ack", 64'(irq_ack), 64'd0);
        check_eq("svc.cause", 64'(cause), 64'd0);
        instruction = 32'hFC000000; tick(); check_trap("svc_und", 3'b101, 2'd1);
        instruction = 32'h00221820; irq_ret = 1'b1; tick(); irq_ret = 1'b0;
        check_eq("ret.in_service", 64'(in_service), 64'd0);
        check_eq("ret.cause", 64'(cause), 64'd0);
        tick();
        check_trap("irq3", 3'b100, 2'd2);
        check_eq("irq3.ack", 64'(irq_ack), 64'b1000);
        irq_ret = 1'b1; tick(); irq_ret = 1'b0;

        // mask blocking and edge during SERVICE
        irq_req = 4'h0; irq_mask = 4'h0; tick();
        irq_req = 4'b0001; tick(); tick();
        check_eq("mask.cause", 64'(cause), 64'd0);
        check_eq("mask.ack", 64'(irq_ack), 64'd0);
        check_eq("mask.in_service", 64'(in_service), 64'd0);
        irq_mask = 4'b1111; tick();
        check_eq("unmask.ack", 64'(irq_ack), 64'b0001);
        check_eq("unmask.cause", 64'(cause), 64'd2);
        irq_req = 4'b0011; tick(); tick();
        check_eq("svc2.ack", 64'(irq_ack), 64'd0);
        check_eq("svc2.cause", 64'(cause), 64'd0);
        check_eq("svc2.in_service", 64'(in_service), 64'd1);
        irq_ret = 1'b1; tick(); irq_ret = 1'b0;
        tick();
        check_eq("svc2_after.ack", 64'(irq_ack), 64'b0010);
        irq_ret = 1'b1; tick(); irq_ret = 1'b0;

        // flush coincident with a pending enabled interrupt
        irq_req = 4'h0; tick();
        irq_req = 4'b0100; tick();
        flush = 1'b1; tick(); flush = 1'b0;
        check_eq("flush.ex_valid", 64'(ex_valid), 64'd0);
        check_eq("flush.RegWr", 64'(RegWr), 64'd0);
        check_eq("flush.ack", 64'(irq_ack), 64'd0);
        check_eq("flush.in_service", 64'(in_service), 64'd0);
        tick();
        check_eq("postflush.ack", 64'(irq_ack), 64'b0100);
        check_eq("postflush.PCSrc", 64'(PCSrc), 64'd4);

        // reset mid-SERVICE with another source pending
        irq_req = 4'h0; tick();
        irq_req = 4'b1000; tick();
        irq_req = 4'h0;
        #3 reset = 1'b0;
        #1;
        check_eq("arst.ex_valid", 64'(ex_valid), 64'd0);
        check_eq("arst.PCSrc", 64'(PCSrc), 64'd0);
        check_eq("arst.cause", 64'(cause), 64'd0);
        check_eq("arst.in_service", 64'(in_service), 64'd0);
        check_eq("arst.pc", 64'(pc_plus_out), 64'd0);
        tick(); reset = 1'b1;
        tick();
        check_eq("postrst.cause", 64'(cause), 64'd0);
        check_eq("postrst.in_service", 64'(in_service), 64'd0);
        check_eq("postrst.ex_valid", 64'(ex_valid), 64'd1);
        id_valid = 1'b0; tick();
        check_eq("bubble.ex_valid", 64'(ex_valid), 64'd0);
        check_eq("bubble.RegWr", 64'(RegWr), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
